uart_rx: RTL and testbench

Serial receiver stage directly downstream of the DDFS baud clock generator. It consumes the 16x-oversampling baud clock as a sampled strobe in the system clock domain and deserialises an asynchronous `RXD` line into parallel bytes. Output is a one-entry holding register with a valid/ready handshake, plus framing-error and overrun flags. It sits between the DDFS baud source and the command/scoreboard logic.

---
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, 3-sample majority per bit, one-entry valid/ready holding register.
// Optional parity bit and PARITY_ERR port are compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2,
   parameter int PARITY_ODD  = 0
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 TICK_16X,
   input  logic                 RXD,
   output logic [DATA_BITS-1:0] DATA,
   output logic                 VALID,
   input  logic                 READY,
   output logic                 FRAME_ERR,
`ifdef UART_RX_PARITY_EN
   output logic                 PARITY_ERR,
`endif
   output logic                 OVERRUN,
   output logic                 BUSY
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   if (DATA_BITS < 5 || DATA_BITS > 8 || SYNC_STAGES < 2 || SYNC_STAGES > 3 ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_rx: illegal parameter value");
   end

   logic [SYNC_STAGES-1:0] rxd_s, tick_s;
   logic                   tick_d, tick, rx, rx_prev, maj, done;
   state_t                 state;
   logic [3:0]             tcnt;
   logic [2:0]             bcnt;
   logic [1:0]             smp;
   logic [DATA_BITS-1:0]   shreg;
`ifdef UART_RX_PARITY_EN
   logic                   par_bit;
`endif

   // tick is registered so it lands SYNC_STAGES+1 cycles after the raw edge, aligned with rx
   always_ff @(posedge CLK) begin
      if (RST) begin
         rxd_s  <= '1;
         tick_s <= '0;
         tick_d <= 1'b0;
         tick   <= 1'b0;
      end else begin
         rxd_s  <= {rxd_s[SYNC_STAGES-2:0], RXD};
         tick_s <= {tick_s[SYNC_STAGES-2:0], TICK_16X};
         tick_d <= tick_s[SYNC_STAGES-1];
         tick   <= tick_s[SYNC_STAGES-1] & ~tick_d;
      end
   end

   assign rx   = rxd_s[SYNC_STAGES-1];
   assign maj  = (smp[1] & smp[0]) | (smp[1] & rx) | (smp[0] & rx);
   assign done = tick && (state == S_STOP) && (tcnt == 4'd9);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_IDLE;
         tcnt    <= '0;
         bcnt    <= '0;
         smp     <= '0;
         shreg   <= '0;
         rx_prev <= 1'b1;
         BUSY    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else if (tick) begin
         rx_prev <= rx;
         if (tcnt == 4'd7 || tcnt == 4'd8) smp <= {smp[0], rx};
         case (state)
            S_IDLE: begin
               tcnt <= '0;
               bcnt <= '0;
               if (rx_prev && !rx) begin
                  state <= S_START;
                  BUSY  <= 1'b1;
               end
            end
            S_START: begin
               tcnt <= tcnt + 4'd1;
               if (tcnt == 4'd9 && maj) begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
                  tcnt  <= '0;
               end else if (tcnt == 4'd15) begin
                  state <= S_DATA;
               end
            end
            S_DATA: begin
               tcnt <= tcnt + 4'd1;
               if (tcnt == 4'd9) shreg <= {maj, shreg[DATA_BITS-1:1]};
               if (tcnt == 4'd15) begin
                  if (bcnt == 3'(DATA_BITS - 1)) begin
                     bcnt  <= '0;
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end else begin
                     bcnt <= bcnt + 3'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               tcnt <= tcnt + 4'd1;
               if (tcnt == 4'd9)  par_bit <= maj;
               if (tcnt == 4'd15) state   <= S_STOP;
            end
`endif
            S_STOP: begin
               // leave at mid-stop so the next start edge is never missed
               if (tcnt == 4'd9) begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
                  tcnt  <= '0;
               end else begin
                  tcnt <= tcnt + 4'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               BUSY  <= 1'b0;
               tcnt  <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         DATA      <= '0;
         VALID     <= 1'b0;
         FRAME_ERR <= 1'b0;
         OVERRUN   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         PARITY_ERR <= 1'b0;
`endif
      end else begin
         OVERRUN <= 1'b0;
         if (done) begin
            if (!VALID || READY) begin
               DATA      <= shreg;
               FRAME_ERR <= !maj;
               VALID     <= 1'b1;
`ifdef UART_RX_PARITY_EN
               PARITY_ERR <= ((^shreg) ^ par_bit) != 1'(PARITY_ODD);
`endif
            end else begin
               OVERRUN <= 1'b1;
            end
         end else if (VALID && READY) begin
            VALID <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: line-level frame generator driven off TICK_16X, accepted words
// collected by a monitor and compared to what each scenario intended to send.
module tb_uart_rx;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       TICK_16X = 1'b0;
   logic       RXD = 1'b1;
   logic       READY = 1'b0;
   logic [7:0] DATA;
   logic       VALID, FRAME_ERR, OVERRUN, BUSY;
`ifdef UART_RX_PARITY_EN
   logic       PARITY_ERR;
`endif

   uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2), .PARITY_ODD(0)) dut (
      .CLK(CLK), .RST(RST), .TICK_16X(TICK_16X), .RXD(RXD),
      .DATA(DATA), .VALID(VALID), .READY(READY), .FRAME_ERR(FRAME_ERR),
`ifdef UART_RX_PARITY_EN
      .PARITY_ERR(PARITY_ERR),
`endif
      .OVERRUN(OVERRUN), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;
   always begin
      repeat (4) @(negedge CLK);
      TICK_16X = ~TICK_16X;
   end

   typedef struct packed {logic pe; logic fe; logic [7:0] d;} rec_t;
   rec_t got[$];
   rec_t exp_q[$];
   int   ovr_cnt = 0, vrise = 0, errors = 0, checks = 0;
   logic v_q = 1'b0;

   // every accepted word, overrun pulse and VALID rising edge
   always @(negedge CLK) begin
      rec_t r;
      r.d  = DATA;
      r.fe = FRAME_ERR;
`ifdef UART_RX_PARITY_EN
      r.pe = PARITY_ERR;
`else
      r.pe = 1'b0;
`endif
      if (VALID && READY) got.push_back(r);
      if (OVERRUN) ovr_cnt++;
      if (VALID && !v_q) vrise++;
      v_q = VALID;
   end

   task automatic sync();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_mon();
      sync();
      got.delete();
      ovr_cnt = 0;
      vrise   = 0;
   endtask

   task automatic set_ready(input logic v);
      sync();
      READY = v;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge TICK_16X);
         RXD = 1'b1;
      end
   endtask

   // expected parity bit for a well-formed frame (even parity)
   function automatic logic good_par(input logic [7:0] d);
      return ^d;
   endfunction

   // one frame, 16 ticks per bit; gbit>=0 inverts tick gk of that data bit
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                             input int gbit, input int gk);
      logic [10:0] lv;
      int nb;
      lv = '0;
      lv[0] = 1'b0;
      lv[8:1] = d;
`ifdef UART_RX_PARITY_EN
      lv[9] = par;  lv[10] = stop; nb = 11;
`else
      lv[9] = stop; nb = 10;
      if (par) lv[10] = 1'b0;
`endif
      for (int i = 0; i < nb; i++)
         for (int k = 0; k < 16; k++) begin
            @(posedge TICK_16X);
            RXD = (gbit >= 0 && i == gbit + 1 && k == gk) ? ~lv[i] : lv[i];
         end
   endtask

   task automatic test_reset();
      sync();
      if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", VALID); end
      checks++;
      if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
      checks++;
      if (DATA !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", DATA); end
      checks++;
      if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", FRAME_ERR); end
      checks++;
      if (OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", OVERRUN); end
      checks++;
   endtask

   task automatic test_single();
      set_ready(1'b1);
      clear_mon();
      send_frame(8'h55, 1'b1, good_par(8'h55), -1, 0);
      idle(8);
      sync();
      if (got.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", got.size()); end
      checks++;
      if (got.size() > 0 && got[0].d !== 8'h55) begin errors++; $display("FAIL single_data: got %h want 55", got[0].d); end
      checks++;
      if (got.size() > 0 && got[0].fe !== 1'b0) begin errors++; $display("FAIL single_ferr: got %b want 0", got[0].fe); end
      checks++;
      if (ovr_cnt !== 0) begin errors++; $display("FAIL single_ovr: got %0d want 0", ovr_cnt); end
      checks++;
      if (vrise !== 1) begin errors++; $display("FAIL single_vpulse: got %0d want 1", vrise); end
      checks++;
   endtask

   task automatic test_back_to_back();
      set_ready(1'b0);
      clear_mon();
      send_frame(8'hA3, 1'b1, good_par(8'hA3), -1, 0);
      send_frame(8'h3C, 1'b1, good_par(8'h3C), -1, 0);
      idle(6);
      sync();
      if (VALID !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", VALID); end
      checks++;
      if (DATA !== 8'hA3) begin errors++; $display("FAIL b2b_hold: got %h want a3", DATA); end
      checks++;
      if (ovr_cnt !== 1) begin errors++; $display("FAIL b2b_ovr: got %0d want 1", ovr_cnt); end
      checks++;
      if (got.size() !== 0) begin errors++; $display("FAIL b2b_early: got %0d want 0", got.size()); end
      checks++;
      set_ready(1'b1);
      repeat (3) sync();
      if (got.size() !== 1 || got[0].d !== 8'hA3) begin
         errors++; $display("FAIL b2b_accept: got n=%0d d=%h want n=1 d=a3", got.size(), got.size() > 0 ? got[0].d : 8'hxx);
      end
      checks++;
      if (VALID !== 1'b0) begin errors++; $display("FAIL b2b_vfall: got %b want 0", VALID); end
      checks++;
   endtask

   task automatic test_false_start();
      logic busy_mid;
      clear_mon();
      repeat (5) begin @(posedge TICK_16X); RXD = 1'b0; end
      repeat (2) sync();
      busy_mid = BUSY;
      idle(16);
      sync();
      if (busy_mid !== 1'b1) begin errors++; $display("FAIL fstart_busy_mid: got %b want 1", busy_mid); end
      checks++;
      if (BUSY !== 1'b0) begin errors++; $display("FAIL fstart_busy_end: got %b want 0", BUSY); end
      checks++;
      if (vrise !== 0) begin errors++; $display("FAIL fstart_novalid: got %0d want 0", vrise); end
      checks++;
   endtask

   task automatic test_frame_err();
      clear_mon();
      send_frame(8'hF0, 1'b0, good_par(8'hF0), -1, 0);
      idle(16);
      send_frame(8'h12, 1'b1, good_par(8'h12), -1, 0);
      idle(8);
      sync();
      if (got.size() !== 2) begin errors++; $display("FAIL ferr_count: got %0d want 2", got.size()); end
      checks++;
      if (got.size() > 0 && {got[0].fe, got[0].d} !== 9'h1F0) begin
         errors++; $display("FAIL ferr_bad: got fe=%b d=%h want fe=1 d=f0", got[0].fe, got[0].d);
      end
      checks++;
      if (got.size() > 1 && {got[1].fe, got[1].d} !== 9'h012) begin
         errors++; $display("FAIL ferr_good: got fe=%b d=%h want fe=0 d=12", got[1].fe, got[1].d);
      end
      checks++;
   endtask

   task automatic test_glitch();
      clear_mon();
      // tick 9 of a bench bit window is the receiver's tcnt=8
      send_frame(8'h00, 1'b1, good_par(8'h00), 3, 9);
      idle(8);
      sync();
      if (got.size() !== 1) begin errors++; $display("FAIL glitch_count: got %0d want 1", got.size()); end
      checks++;
      if (got.size() > 0 && {got[0].fe, got[0].d} !== 9'h000) begin
         errors++; $display("FAIL glitch_data: got fe=%b d=%h want fe=0 d=00", got[0].fe, got[0].d);
      end
      checks++;
   endtask

   task automatic test_break();
      clear_mon();
      repeat (200) begin @(posedge TICK_16X); RXD = 1'b0; end
      idle(20);
      sync();
      if (got.size() !== 1) begin errors++; $display("FAIL break_count: got %0d want 1", got.size()); end
      checks++;
      if (got.size() > 0 && {got[0].fe, got[0].d} !== 9'h100) begin
         errors++; $display("FAIL break_data: got fe=%b d=%h want fe=1 d=00", got[0].fe, got[0].d);
      end
      checks++;
   endtask

   task automatic test_reset_abort();
      logic [9:0] lv;
      clear_mon();
      lv = {1'b1, 8'h5A, 1'b0};
      for (int t = 0; t < 5 * 16 + 8; t++) begin
         @(posedge TICK_16X);
         RXD = lv[t / 16];
      end
      sync();
      RST = 1'b1;
      repeat (2) sync();
      RST = 1'b0;
      RXD = 1'b1;
      sync();
      if (BUSY !== 1'b0 || VALID !== 1'b0) begin
         errors++; $display("FAIL abort_state: got busy=%b valid=%b want 0 0", BUSY, VALID);
      end
      checks++;
      idle(4);
`ifdef UART_RX_PARITY_EN
      send_frame(8'h81, 1'b1, 1'b1, -1, 0);
`else
      send_frame(8'h81, 1'b1, 1'b0, -1, 0);
`endif
      idle(8);
      sync();
      if (got.size() !== 1) begin errors++; $display("FAIL abort_count: got %0d want 1", got.size()); end
      checks++;
      if (got.size() > 0 && {got[0].fe, got[0].d} !== 9'h081) begin
         errors++; $display("FAIL abort_data: got fe=%b d=%h want fe=0 d=81", got[0].fe, got[0].d);
      end
      checks++;
`ifdef UART_RX_PARITY_EN
      if (got.size() > 0 && got[0].pe !== 1'b1) begin errors++; $display("FAIL abort_perr: got %b want 1", got[0].pe); end
      checks++;
`endif
   endtask

   task automatic test_random();
      clear_mon();
      exp_q.delete();
      for (int n = 0; n < 5; n++) begin
         rec_t e;
         e.d  = 8'($urandom);
         e.fe = ($urandom_range(0, 3) == 0);
         e.pe = 1'b0;
         exp_q.push_back(e);
         send_frame(e.d, !e.fe, good_par(e.d), -1, 0);
         idle($urandom_range(1, 20));
      end
      idle(4);
      sync();
      if (got.size() !== exp_q.size()) begin
         errors++; $display("FAIL rand_count: got %0d want %0d", got.size(), exp_q.size());
      end
      checks++;
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         if (got[i] !== exp_q[i]) begin
            errors++; $display("FAIL rand_word%0d: got fe=%b d=%h want fe=%b d=%h",
                               i, got[i].fe, got[i].d, exp_q[i].fe, exp_q[i].d);
         end
         checks++;
      end
   endtask

   initial begin
      repeat (4) @(posedge CLK);
      #1 RST = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_false_start();
      test_frame_err();
      test_glitch();
      test_break();
      test_reset_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
